alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Front-end controller for the 32-bit ALU datapath: the bitwise gate arrays and the ripple adder/subtractor.
- Accepts one operation request at a time over a valid/ready handshake and drives the shared ALU with the captured operands.
- Reuses the ALU adder for an iterative 32-step shift-add unsigned multiply.
- Returns the result over a valid/ready response handshake; sits between the register-file/issue logic and the ALU.

Parameters:
- WIDTH, 32, operand width; the multiply produces 2*WIDTH bits.
- CNT_W, 6, step-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLT, 110 NOR, 111 MUL.
- req_a  in  WIDTH  operand A; multiplicand for MUL.
- req_b  in  WIDTH  operand B; multiplier for MUL.
- alu_op  out  3  opcode driven to the ALU; values 000-110 only.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_y  in  WIDTH  combinational ALU result.
- alu_cout  in  1  ALU adder carry-out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_lo  out  WIDTH  result; low product half for MUL.
- rsp_hi  out  WIDTH  high product half for MUL; 0 for all other ops.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; counter, operand and product registers cleared; rsp_valid=0, rsp_lo=0, rsp_hi=0, req_ready=1.
- Reset asserted mid-operation aborts the operation with no response.
- FSM states: IDLE, EXEC, MUL, DONE. req_ready=1 only in IDLE.
- IDLE: on req_valid&&req_ready, capture op, a and b. Go to MUL if op=111, else EXEC.
- EXEC: alu_op=op, alu_a=a, alu_b=b. Latch rsp_lo<=alu_y, rsp_hi<=0, then go to DONE.
  - rsp_valid rises 2 cycles after the accepting edge.
- MUL: product register {P_hi, P_lo}, initialised to {0, b} on acceptance. Counter starts at 0. Each cycle:
  - alu_op=ADD, alu_a=P_hi, alu_b = P_lo[0] ? a : 0.
  - Update {P_hi, P_lo} <= {alu_cout, alu_y, P_lo} >> 1, taking the low 2*WIDTH bits.
  - Counter increments; after step WIDTH-1 go to DONE and load rsp_hi/rsp_lo from the product.
  - rsp_valid rises WIDTH+1 = 33 cycles after the accepting edge.
- DONE: rsp_valid=1; rsp_lo/rsp_hi held stable until rsp_valid&&rsp_ready. Then go to IDLE and clear rsp_valid.
  - req_ready returns the following cycle; there is no same-cycle accept after a response.
- Outside EXEC/MUL: alu_op=000, alu_a=0, alu_b=0.
- Requests with req_ready=0 are ignored and are not queued.
- Multiply is unsigned. 0 x anything still takes the full WIDTH steps.
- All response outputs are registered.

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- Defined: adds output ports rsp_zero, rsp_carry, rsp_ovf, registered with rsp_lo.
  - rsp_zero: rsp_hi==0 && rsp_lo==0.
  - rsp_carry: alu_cout for ADD/SUB; 0 otherwise.
  - rsp_ovf: signed overflow for ADD/SUB, computed from operand and result MSBs; 0 otherwise.
  - All three reset to 0.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_AND..OP_MUL;
  - FSM state encoding ST_IDLE, ST_EXEC, ST_MUL, ST_DONE;
  - WIDTH default.
- One natural sub-module, alu_mul_step_cnt: CNT_W-bit counter with clear/enable and a last-step flag at WIDTH-1.

Test Plan:
- OR, a=0xF0F00000, b=0x00000F0F -> alu_op=001 in EXEC; rsp_lo=0xF0F00F0F, rsp_hi=0; rsp_valid at accept+2.
- MUL 7 x 6 -> rsp_hi=0, rsp_lo=42 at accept+33; alu_op=011 for all 32 MUL cycles.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> rsp_hi=0xFFFFFFFE, rsp_lo=0x00000001; carry path exercised.
- SUB 5-7 with rsp_ready low for 10 cycles -> rsp_lo=0xFFFFFFFE held stable, rsp_valid stays 1.
  - A second req_valid during the hold is not accepted (req_ready=0).
  - req_ready=1 one cycle after the handshake.
- reset pulsed at MUL step 15 -> outputs zero immediately.
  - A following ADD 1+1 returns rsp_lo=2 with no stale multiply response.
- With ALU_SEQ_FLAGS_EN: ADD 0x7FFFFFFF+1 -> rsp_ovf=1, rsp_carry=0, rsp_zero=0.
  - Then ADD 0xFFFFFFFF+1 -> rsp_zero=1, rsp_carry=1, rsp_ovf=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg - shared definitions for the ALU front-end controller.
//   ALU_WIDTH : default datapath width
//   op_e      : request/ALU opcode encoding (OP_MUL is sequencer-only)
//   state_e   : sequencer FSM states
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_XOR = 3'b010,
      OP_ADD = 3'b011,
      OP_SUB = 3'b100,
      OP_SLT = 3'b101,
      OP_NOR = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_MUL  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/alu_mul_step_cnt.sv
// alu_mul_step_cnt - step counter for the iterative shift-add multiply.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear (new multiply accepted)
//   en         : advance one step
//   last       : high while the counter holds the final step index WIDTH-1
module alu_mul_step_cnt #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic last
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer - front-end controller for the shared 32-bit ALU.
// Accepts one request at a time (req_*), drives the ALU (alu_*), and returns
// a registered result (rsp_*). MUL is an unsigned WIDTH-step shift-add that
// reuses the ALU adder; rsp_hi carries the high product half (0 otherwise).
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   req_valid/req_ready             : request handshake
//   req_op, req_a, req_b            : opcode and operands
//   alu_op, alu_a, alu_b            : ALU drive (zero outside EXEC/MUL)
//   alu_y, alu_cout                 : ALU result and adder carry-out
//   rsp_valid/rsp_ready             : response handshake
//   rsp_lo, rsp_hi                  : result / product halves
// Optional (macro ALU_SEQ_FLAGS_EN): rsp_zero, rsp_carry, rsp_ovf flags,
// registered alongside rsp_lo.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_lo,
   output logic [WIDTH-1:0] rsp_hi
`ifdef ALU_SEQ_FLAGS_EN
  ,output logic             rsp_zero,
   output logic             rsp_carry,
   output logic             rsp_ovf
`endif
);

   state_e           state, state_n;
   op_e              op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] p_hi, p_lo;
   logic             accept;
   logic             last;
   logic [2*WIDTH-1:0] prod_n;

   // {alu_cout, alu_y, p_lo} >> 1, truncated to 2*WIDTH bits
   assign prod_n = {alu_cout, alu_y, p_lo[WIDTH-1:1]};

   assign req_ready = (state == ST_IDLE);

   alu_mul_step_cnt #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (accept),
      .en    (state == ST_MUL),
      .last  (last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      alu_op  = OP_AND;
      alu_a   = '0;
      alu_b   = '0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               accept  = 1'b1;
               state_n = (op_e'(req_op) == OP_MUL) ? ST_MUL : ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_op  = op_q;
            alu_a   = a_q;
            alu_b   = b_q;
            state_n = ST_DONE;
         end
         ST_MUL: begin
            alu_op = OP_ADD;
            alu_a  = p_hi;
            alu_b  = p_lo[0] ? a_q : '0;
            if (last)
               state_n = ST_DONE;
         end
         ST_DONE: begin
            if (rsp_ready)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

`ifdef ALU_SEQ_FLAGS_EN
   logic is_addsub, ovf_add, ovf_sub;
   assign is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
   // Signed overflow: ADD when operands agree in sign, SUB when they differ,
   // and the result sign differs from A.
   assign ovf_add = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_y[WIDTH-1] != a_q[WIDTH-1]);
   assign ovf_sub = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_y[WIDTH-1] != a_q[WIDTH-1]);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q      <= OP_AND;
         a_q       <= '0;
         b_q       <= '0;
         p_hi      <= '0;
         p_lo      <= '0;
         rsp_valid <= 1'b0;
         rsp_lo    <= '0;
         rsp_hi    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
         rsp_zero  <= 1'b0;
         rsp_carry <= 1'b0;
         rsp_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q <= op_e'(req_op);
                  a_q  <= req_a;
                  b_q  <= req_b;
                  p_hi <= '0;
                  p_lo <= req_b;
               end
            end
            ST_EXEC: begin
               rsp_lo    <= alu_y;
               rsp_hi    <= '0;
               rsp_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
               rsp_zero  <= (alu_y == '0);
               rsp_carry <= is_addsub & alu_cout;
               rsp_ovf   <= ((op_q == OP_ADD) & ovf_add) | ((op_q == OP_SUB) & ovf_sub);
`endif
            end
            ST_MUL: begin
               {p_hi, p_lo} <= prod_n;
               if (last) begin
                  {rsp_hi, rsp_lo} <= prod_n;
                  rsp_valid        <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                  rsp_zero  <= (prod_n == '0);
                  rsp_carry <= 1'b0;
                  rsp_ovf   <= 1'b0;
`endif
               end
            end
            ST_DONE: begin
               if (rsp_ready)
                  rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
